// File: rtl/score_display_scheduler_if.sv
// Score load/display bus between the score source and the display scheduler.
interface score_display_scheduler_if;
    logic [15:0] points;
    logic        load;
    logic        busy;
    logic        overflow;
    logic [3:0]  bcd;
    logic [3:0]  an;

    modport master (
        output points, load,
        input  busy, overflow, bcd, an
    );

    modport slave (
        input  points, load,
        output busy, overflow, bcd, an
    );
endinterface

// File: rtl/score_display_scheduler.sv
// Clamps a binary score to 9999, converts it to BCD with a sequential double-dabble,
// and time-multiplexes the four digits onto a shared seven-segment bus.
module score_display_scheduler #(
    parameter int unsigned CLKS_PER_DIGIT = 50000,
    parameter bit          BLANK_LEADING  = 1'b1
) (
    input logic                       clk,
    input logic                       reset,
    score_display_scheduler_if.slave  bus
);
    localparam int unsigned VAL_W = 16;
    localparam int unsigned CNT_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam logic [VAL_W-1:0] MAX_VAL  = VAL_W'(9999);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);

    typedef enum logic [1:0] {IDLE, CLAMP, SHIFT, COMMIT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [VAL_W-1:0] val_q;
    logic [VAL_W-1:0] pend_val_q;
    logic             pend_q;
    logic [VAL_W-1:0] bin_q;
    logic [VAL_W-1:0] acc_q;
    logic [14:0]      acc_adj;
    logic [3:0]       iter_q;
    logic             clamp_q;
    logic [VAL_W-1:0] disp_q;
    logic             ovf_q;
    logic             busy_q;
    logic [CNT_W-1:0] ref_cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       digit;
    logic             blank;

    // Converter state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Converter next-state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load) state_nxt = CLAMP;
            CLAMP:   state_nxt = SHIFT;
            SHIFT:   if (iter_q == 4'd15) state_nxt = COMMIT;
            COMMIT:  state_nxt = (pend_q || bus.load) ? CLAMP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction; the top nibble never reaches 5 because the value is clamped to 9999
    always_comb begin
        acc_adj = acc_q[14:0];
        for (int i = 0; i < 3; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath, pending slot and display registers
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q      <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            bin_q      <= '0;
            acc_q      <= '0;
            iter_q     <= '0;
            clamp_q    <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (bus.load) val_q <= bus.points;
                end
                CLAMP: begin
                    if (val_q > MAX_VAL) begin
                        bin_q   <= MAX_VAL;
                        clamp_q <= 1'b1;
                    end else begin
                        bin_q   <= val_q;
                        clamp_q <= 1'b0;
                    end
                    acc_q  <= '0;
                    iter_q <= '0;
                    if (bus.load) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= bus.points;
                    end
                end
                SHIFT: begin
                    acc_q  <= {acc_adj, bin_q[VAL_W-1]};
                    bin_q  <= {bin_q[VAL_W-2:0], 1'b0};
                    iter_q <= iter_q + 4'd1;
                    if (bus.load) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= bus.points;
                    end
                end
                COMMIT: begin
                    disp_q <= acc_q;
                    ovf_q  <= clamp_q;
                    pend_q <= 1'b0;
                    // A load arriving in this cycle is newer than anything pending
                    if (bus.load)   val_q <= bus.points;
                    else if (pend_q) val_q <= pend_val_q;
                end
                default: ;
            endcase
        end
    end

    // Free-running digit refresh
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
        end else if (ref_cnt_q == CNT_LAST) begin
            ref_cnt_q <= '0;
            idx_q     <= idx_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + CNT_W'(1);
        end
    end

    // Digit select and leading-zero blanking
    always_comb begin
        digit = disp_q[3:0];
        blank = 1'b0;
        case (idx_q)
            2'd0: begin digit = disp_q[3:0];   blank = 1'b0;                    end
            2'd1: begin digit = disp_q[7:4];   blank = (disp_q[15:4]  == 12'h0); end
            2'd2: begin digit = disp_q[11:8];  blank = (disp_q[15:8]  == 8'h0);  end
            2'd3: begin digit = disp_q[15:12]; blank = (disp_q[15:12] == 4'h0);  end
            default: ;
        endcase
        blank   = blank && BLANK_LEADING;
        bus.an  = 4'b1111;
        if (!blank) bus.an[idx_q] = 1'b0;
        bus.bcd = digit;
    end

    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
endmodule

// File: doc/score_display_scheduler.md
SCORE_DISPLAY_SCHEDULER -- requirements
Module: score_display_scheduler

Interface
REQ-001 SHALL have parameter CLKS_PER_DIGIT, default 50000, giving clk cycles each digit is lit (1 ms at 50 MHz).
REQ-002 SHALL have parameter BLANK_LEADING, default 1; when 1, leading-zero digits above digit 0 are blanked.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port points  input  16  unsigned score, sampled only on an accepted load.
REQ-006 SHALL have port load  input  1  single-cycle request to convert and display points.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port overflow  output  1  high when the displayed value was clamped.
REQ-009 SHALL have port bcd  output  4  BCD nibble of the currently selected digit, to the seven_seg decoder.
REQ-010 SHALL have port an  output  4  active-low one-hot digit anode enables; an[0] is the units digit.

Function
REQ-011 Converter FSM SHALL have states IDLE, CLAMP, SHIFT, COMMIT; busy = (state != IDLE).
REQ-012 In IDLE with load=1, the FSM SHALL capture points and enter CLAMP at the next edge.
REQ-013 CLAMP SHALL last 1 cycle: value > 9999 is replaced by 9999 with a clamp flag set; otherwise value unchanged and flag cleared.
REQ-014 SHALL perform a 16-iteration shift-add-3 (double-dabble) binary-to-BCD conversion, one iteration per cycle, 16 cycles, then enter COMMIT.
REQ-015 COMMIT SHALL last 1 cycle, copy all four BCD digits and the clamp flag into the display registers atomically, and update overflow.
REQ-016 Latency: load accepted at edge k -> busy high after edge k; display registers and overflow update at edge k+18, and busy falls at the same edge unless a pending load exists.
REQ-017 Display registers SHALL NOT change at any time other than COMMIT or reset; partial conversion results never reach bcd.
REQ-018 A load while busy SHALL set a one-entry pending flag and store points in a pending register; a further load while busy overwrites the pending value (last wins).
REQ-019 At COMMIT with pending set, the FSM SHALL go to CLAMP with the pending value and clear pending; busy stays high without a gap.
REQ-020 Load in the same cycle as COMMIT SHALL be treated as pending and start immediately after COMMIT.
REQ-021 Refresh counter SHALL count 0..CLKS_PER_DIGIT-1 continuously, independent of the converter; at terminal count it wraps to 0 and digit index advances 0->1->2->3->0.
REQ-022 bcd and an SHALL be combinational decodes of the registered digit index and display registers only: index i drives an = all ones except bit i low, bcd = digit i.
REQ-023 With BLANK_LEADING=1, digit i (i>=1) SHALL be blanked (an = 4'b1111) while it and all higher digits are zero; digit 0 is never blanked.
REQ-024 With BLANK_LEADING=0, all four digits SHALL be lit in turn, including zeros.
REQ-025 Display multiplexing SHALL continue unchanged while a conversion is in progress.

Reset
REQ-026 reset=1 SHALL dominate load and all other activity, taking effect at the next edge, including mid-conversion.
REQ-027 After reset: state IDLE, busy=0, pending cleared, display registers 0, overflow=0, refresh counter 0, digit index 0, an=4'b1110, bcd=4'h0.

Verification (CLKS_PER_DIGIT=4)
REQ-028 Assert reset 2 cycles -> busy=0, overflow=0, an=1110, bcd=0; hold 16 cycles -> an walks 1110,1101*,1011*,0111* (*blanked to 1111 when BLANK_LEADING=1).
REQ-029 load with points=1234 -> busy high exactly 18 cycles; afterwards bcd=4,3,2,1 with an=1110,1101,1011,0111, 4 cycles each, repeating; overflow=0.
REQ-030 load with points=12345 -> after 18 cycles, display 9,9,9,9 and overflow=1; later load with points=5 -> overflow=0, display 5.
REQ-031 BLANK_LEADING=1, load points=7 -> digit 0 shows bcd=7, an=1110; digit slots 1-3 give an=1111; points=1002 -> all four digits lit (1,0,0,2).
REQ-032 load 42, then load 100 at cycle 5 and load 250 at cycle 9 of busy -> first COMMIT shows 42, busy stays high continuously, second COMMIT (18 cycles later) shows 250; 100 is never displayed.
REQ-033 load 9999, assert reset at busy cycle 10 -> next edge busy=0, display 0, an=1110; no later COMMIT occurs.
